// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target: decodes a 2^ADDR_BITS byte window at BASE_ADDR and bridges
// IORD/IOWR to a strobe/ready register bus, with long-wait SYNC and a bounded timeout.
module lpc_io_target #(
    parameter logic [15:0] BASE_ADDR = 16'h03F8,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned WAIT_MAX  = 16
) (
    input  logic                 lpc_clk,
    input  logic                 lpc_rst,
    input  logic                 lpc_frame,
    inout  logic [3:0]           lpc_ad,
    output logic [ADDR_BITS-1:0] reg_addr,
    output logic [7:0]           reg_wdata,
    output logic                 reg_wr,
    output logic                 reg_rd,
    input  logic [7:0]           reg_rdata,
    input  logic                 reg_ready,
    output logic                 cycle_err
);

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_CTDIR, S_ADDR, S_WDATA, S_HTAR0,
        S_HTAR1, S_SYNC, S_RDATA, S_TTAR0, S_TTAR1
    } state_t;

    state_t               state;
    logic [1:0]           rst_sync;
    logic                 is_wr;
    logic [1:0]           cnt;
    logic [11:0]          addr_sr;
    logic [ADDR_BITS-1:0] addr_lo;
    logic [3:0]           wlo;
    logic [7:0]           wait_cnt;
    logic [7:0]           rdata;
    logic [3:0]           lad_out;
    logic                 lad_oe;
    logic                 lad_drive;
    logic [15:0]          addr_full;
    logic                 addr_hit;

    // A host asserting LFRAME# always owns the bus, so release LAD combinationally.
    assign lad_drive = lad_oe & lpc_frame;
    assign lpc_ad    = lad_drive ? lad_out : 4'bzzzz;

    assign addr_full = {addr_sr, lpc_ad};
    assign addr_hit  = (addr_full[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);

    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            rst_sync  <= '0;
            state     <= S_IDLE;
            is_wr     <= 1'b0;
            cnt       <= '0;
            addr_sr   <= '0;
            addr_lo   <= '0;
            wlo       <= '0;
            wait_cnt  <= '0;
            rdata     <= '0;
            lad_out   <= '0;
            lad_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            cycle_err <= 1'b0;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            cycle_err <= 1'b0;

            if (state != S_IDLE && !lpc_frame) begin
                // Abort; a START nibble in the same cycle begins a new cycle.
                lad_oe   <= 1'b0;
                wait_cnt <= '0;
                state    <= (lpc_ad == 4'h0) ? S_CTDIR : S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!lpc_frame && lpc_ad == 4'h0 && rst_sync[1])
                            state <= S_CTDIR;
                    end
                    S_CTDIR: begin
                        if (lpc_ad[3:2] == 2'b00) begin
                            is_wr <= lpc_ad[1];
                            cnt   <= '0;
                            state <= S_ADDR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_ADDR: begin
                        addr_sr <= addr_full[11:0];
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (!addr_hit) begin
                                state <= S_IDLE;
                            end else if (is_wr) begin
                                addr_lo <= addr_full[ADDR_BITS-1:0];
                                state   <= S_WDATA;
                            end else begin
                                reg_addr <= addr_full[ADDR_BITS-1:0];
                                reg_rd   <= 1'b1;
                                state    <= S_HTAR0;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (!cnt[0]) begin
                            wlo <= lpc_ad;
                            cnt <= 2'd1;
                        end else begin
                            reg_wdata <= {lpc_ad, wlo};
                            reg_addr  <= addr_lo;
                            reg_wr    <= 1'b1;
                            state     <= S_HTAR0;
                        end
                    end
                    S_HTAR0: state <= S_HTAR1;
                    S_HTAR1: begin
                        lad_oe <= 1'b1;
                        state  <= S_SYNC;
                        if (reg_ready) begin
                            lad_out  <= 4'h0;
                            rdata    <= reg_rdata;
                            wait_cnt <= '0;
                        end else begin
                            lad_out  <= 4'h6;
                            wait_cnt <= 8'd1;
                        end
                    end
                    S_SYNC: begin
                        if (lad_out == 4'h6) begin
                            if (reg_ready) begin
                                lad_out <= 4'h0;
                                rdata   <= reg_rdata;
                            end else if (wait_cnt == WAIT_LIM) begin
                                lad_out   <= 4'hA;
                                rdata     <= 8'hFF;
                                cycle_err <= 1'b1;
                            end else begin
                                wait_cnt <= wait_cnt + 8'd1;
                            end
                        end else begin
                            wait_cnt <= '0;
                            cnt      <= '0;
                            if (is_wr) begin
                                lad_out <= 4'hF;
                                state   <= S_TTAR0;
                            end else begin
                                lad_out <= rdata[3:0];
                                state   <= S_RDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (!cnt[0]) begin
                            lad_out <= rdata[7:4];
                            cnt     <= 2'd1;
                        end else begin
                            lad_out <= 4'hF;
                            state   <= S_TTAR0;
                        end
                    end
                    S_TTAR0: begin
                        lad_oe <= 1'b0;
                        state  <= S_TTAR1;
                    end
                    S_TTAR1: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_target.sv
// Directed bench for lpc_io_target: table of IORD/IOWR transactions plus
// hand sequences for memory-cycle rejection, abort-as-START and mid-cycle reset.
module tb_lpc_io_target;

    logic       clk = 1'b0;
    logic       lpc_rst = 1'b0;
    logic       frame = 1'b1;
    logic       host_oe = 1'b1;
    logic [3:0] host_ad = 4'hF;
    wire  [3:0] lpc_ad;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr, reg_rd, cycle_err;
    logic [7:0] reg_rdata = 8'h00;
    logic       reg_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    int unsigned wr_cnt = 0, rd_cnt = 0, err_cnt = 0, drv_cnt = 0, cf_cnt = 0;
    logic [2:0]  last_addr = '0;
    logic [7:0]  last_wdata = '0;

    assign lpc_ad = host_oe ? host_ad : 4'bzzzz;

    always #5 clk = ~clk;

    lpc_io_target #(
        .BASE_ADDR(16'h03F8),
        .ADDR_BITS(3),
        .WAIT_MAX (8)
    ) dut (
        .lpc_clk  (clk),
        .lpc_rst  (lpc_rst),
        .lpc_frame(frame),
        .lpc_ad   (lpc_ad),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_rdata(reg_rdata),
        .reg_ready(reg_ready),
        .cycle_err(cycle_err)
    );

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt     <= wr_cnt + 1;
            last_addr  <= reg_addr;
            last_wdata <= reg_wdata;
        end
        if (reg_rd) begin
            rd_cnt    <= rd_cnt + 1;
            last_addr <= reg_addr;
        end
        if (cycle_err)                  err_cnt <= err_cnt + 1;
        if (dut.lad_drive)              drv_cnt <= drv_cnt + 1;
        if (dut.lad_drive && host_oe)   cf_cnt  <= cf_cnt + 1;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int unsigned dly;
        logic        hit;
        int          exp_sixes;
        logic [3:0]  exp_final;
        logic [7:0]  exp_rdata;
        int          exp_clocks;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(inout int n);
        n++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n = 0;
        int sixes = 0;
        int clocks = 0;
        bit got = 1'b0;
        logic [3:0] fin = 4'h5, dlo = 4'h0, dhi = 4'h0, tt0 = 4'h0;
        logic tt1_drv = 1'b1;
        int unsigned wr0 = wr_cnt, rd0 = rd_cnt, er0 = err_cnt, dv0 = drv_cnt, cf0 = cf_cnt;
        int exp_drv;

        reg_rdata = v.rdata;
        reg_ready = 1'b0;
        host_oe = 1'b1; frame = 1'b0; host_ad = 4'h0; step(n);
        frame = 1'b1; host_ad = v.wr ? 4'h2 : 4'h0; step(n);
        for (int i = 0; i < 4; i++) begin
            host_ad = v.addr[15-4*i -: 4];
            step(n);
        end
        if (v.wr) begin
            host_ad = v.wdata[3:0]; step(n);
            host_ad = v.wdata[7:4]; step(n);
        end
        host_ad = 4'hF; reg_ready = (v.dly == 0); step(n);
        host_oe = 1'b0; reg_ready = (v.dly <= 1); step(n);
        for (int k = 0; k < 40; k++) begin
            if (!dut.lad_drive) begin
                if (k >= 4) break;
                step(n);
                continue;
            end
            if (lpc_ad == 4'h6) begin
                sixes++;
                reg_ready = (32'(k + 2) >= v.dly);
                step(n);
            end else begin
                fin = lpc_ad;
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            step(n);
            if (!v.wr) begin
                dlo = lpc_ad; step(n);
                dhi = lpc_ad; step(n);
            end
            tt0 = lpc_ad; step(n);
            clocks = n;
            tt1_drv = dut.lad_drive;
        end
        host_oe = 1'b1; frame = 1'b1; host_ad = 4'hF; reg_ready = 1'b0; step(n);

        exp_drv = v.hit ? (v.exp_sixes + 1 + (v.wr ? 1 : 3)) : 0;
        chk($sformatf("v%0d wr_strobes", idx), wr_cnt - wr0, (v.hit && v.wr) ? 1 : 0);
        chk($sformatf("v%0d rd_strobes", idx), rd_cnt - rd0, (v.hit && !v.wr) ? 1 : 0);
        chk($sformatf("v%0d err_pulses", idx), err_cnt - er0, (v.hit && v.exp_final == 4'hA) ? 1 : 0);
        chk($sformatf("v%0d drive_cycles", idx), drv_cnt - dv0, exp_drv);
        chk($sformatf("v%0d bus_conflicts", idx), cf_cnt - cf0, 0);
        if (v.hit) begin
            chk($sformatf("v%0d reg_addr", idx), last_addr, v.addr[2:0]);
            chk($sformatf("v%0d sync_waits", idx), sixes, v.exp_sixes);
            chk($sformatf("v%0d sync_final", idx), fin, v.exp_final);
            chk($sformatf("v%0d clocks", idx), clocks, v.exp_clocks);
            chk($sformatf("v%0d ttar0", idx), tt0, 4'hF);
            chk($sformatf("v%0d ttar1_drive", idx), tt1_drv, 1'b0);
            if (v.wr) chk($sformatf("v%0d reg_wdata", idx), last_wdata, v.wdata);
            else      chk($sformatf("v%0d read_data", idx), {dhi, dlo}, v.exp_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d = 0;
        int unsigned wr0, dv0;
        vec_t va;

        vecs[0] = '{1'b1, 16'h03F8, 8'h5A, 8'h00, 0,   1'b1, 0, 4'h0, 8'h00, 12};
        vecs[1] = '{1'b0, 16'h03FD, 8'h00, 8'h60, 3,   1'b1, 2, 4'h0, 8'h60, 14};
        vecs[2] = '{1'b0, 16'h02F8, 8'h00, 8'h11, 1,   1'b0, 0, 4'h0, 8'h00, 0};
        vecs[3] = '{1'b0, 16'h03FA, 8'h00, 8'h33, 255, 1'b1, 8, 4'hA, 8'hFF, 20};
        vecs[4] = '{1'b1, 16'h03FF, 8'hC3, 8'h00, 1,   1'b1, 0, 4'h0, 8'h00, 12};
        vecs[5] = '{1'b0, 16'h03F8, 8'h00, 8'h9E, 1,   1'b1, 0, 4'h0, 8'h9E, 12};
        vecs[6] = '{1'b1, 16'h03F0, 8'h77, 8'h00, 0,   1'b0, 0, 4'h0, 8'h00, 0};
        vecs[7] = '{1'b0, 16'h0BF8, 8'h00, 8'h44, 1,   1'b0, 0, 4'h0, 8'h00, 0};
        vecs[8] = '{1'b1, 16'h03FB, 8'h3C, 8'h00, 2,   1'b1, 1, 4'h0, 8'h00, 13};

        #3;
        chk("reset reg_wr", reg_wr, 1'b0);
        chk("reset reg_rd", reg_rd, 1'b0);
        chk("reset cycle_err", cycle_err, 1'b0);
        chk("reset reg_addr", reg_addr, 3'd0);
        chk("reset reg_wdata", reg_wdata, 8'h00);
        chk("reset lad_drive", dut.lad_drive, 1'b0);
        @(posedge clk); @(posedge clk); #2;
        lpc_rst = 1'b1;
        for (int i = 0; i < 4; i++) step(d);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Memory-cycle code in CTDIR must be ignored.
        wr0 = wr_cnt + rd_cnt; dv0 = drv_cnt;
        frame = 1'b0; host_ad = 4'h0; step(d);
        frame = 1'b1; host_ad = 4'h4; step(d);
        for (int i = 0; i < 8; i++) begin host_ad = 4'(i); step(d); end
        host_ad = 4'hF; step(d);
        chk("memcyc strobes", wr_cnt + rd_cnt - wr0, 0);
        chk("memcyc drive", drv_cnt - dv0, 0);
        run_vec(20, vecs[5]);

        // Abort after two address nibbles, with START in the abort cycle.
        wr0 = wr_cnt + rd_cnt; dv0 = drv_cnt;
        frame = 1'b0; host_ad = 4'h0; step(d);
        frame = 1'b1; host_ad = 4'h2; step(d);
        host_ad = 4'h0; step(d);
        host_ad = 4'h3; step(d);
        va = '{1'b1, 16'h03F9, 8'hA5, 8'h00, 1, 1'b1, 0, 4'h0, 8'h00, 12};
        run_vec(21, va);
        chk("abort total strobes", wr_cnt + rd_cnt - wr0, 1);

        // Reset asserted during SYNC.
        reg_ready = 1'b0;
        frame = 1'b0; host_ad = 4'h0; step(d);
        frame = 1'b1; host_ad = 4'h0; step(d);
        host_ad = 4'h0; step(d);
        host_ad = 4'h3; step(d);
        host_ad = 4'hF; step(d);
        host_ad = 4'hE; step(d);
        host_ad = 4'hF; step(d);
        host_oe = 1'b0; step(d);
        chk("sync driven", dut.lad_drive, 1'b1);
        chk("sync wait nibble", lpc_ad, 4'h6);
        chk("pre-reset reg_addr", reg_addr, 3'd6);
        #2 lpc_rst = 1'b0;
        #1;
        chk("midreset lad_drive", dut.lad_drive, 1'b0);
        chk("midreset reg_addr", reg_addr, 3'd0);
        chk("midreset reg_wdata", reg_wdata, 8'h00);
        chk("midreset reg_rd", reg_rd, 1'b0);
        chk("midreset cycle_err", cycle_err, 1'b0);

        // START on the first edge after release must be ignored.
        @(posedge clk); #2;
        wr0 = wr_cnt + rd_cnt; dv0 = drv_cnt;
        host_oe = 1'b1; frame = 1'b0; host_ad = 4'h0; lpc_rst = 1'b1;
        @(posedge clk); #1;
        frame = 1'b1; host_ad = 4'h2; step(d);
        host_ad = 4'h0; step(d);
        host_ad = 4'h3; step(d);
        host_ad = 4'hF; step(d);
        host_ad = 4'h8; step(d);
        host_ad = 4'h1; step(d);
        host_ad = 4'h2; step(d);
        host_ad = 4'hF; step(d);
        host_oe = 1'b0; step(d); step(d); step(d);
        host_oe = 1'b1; host_ad = 4'hF; step(d);
        chk("early start strobes", wr_cnt + rd_cnt - wr0, 0);
        chk("early start drive", drv_cnt - dv0, 0);

        va = '{1'b1, 16'h03FC, 8'h11, 8'h00, 0, 1'b1, 0, 4'h0, 8'h00, 12};
        run_vec(22, va);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_io_target.md
# lpc_io_target

Parametrised LPC I/O-cycle target that decodes a window of 2^ADDR_BITS byte registers at BASE_ADDR and bridges it to a simple register bus with a ready handshake. It generalises the fixed single-port UART decode: the window base and size are configurable, both IORD and IOWR are supported, and slow back-ends are absorbed with long-wait SYNC. A bounded timeout reports SYNC error. It sits between the LPC pins and peripheral register files such as the UART.

## Interface
- BASE_ADDR, 16'h03F8, I/O base; must be aligned to 2^ADDR_BITS
- ADDR_BITS, 3, register window size is 2^ADDR_BITS bytes (1..8)
- WAIT_MAX, 16, max long-wait SYNC cycles before error (1..255)

Ports:
- lpc_clk  in  1  LPC clock; all logic on rising edge
- lpc_rst  in  1  reset, asynchronous, active-low
- lpc_frame  in  1  LFRAME#, active-low
- lpc_ad  inout  4  LAD[3:0]; driven only in target-owned states, else Z
- reg_addr  out  ADDR_BITS  register offset (address − BASE_ADDR)
- reg_wdata  out  8  write data
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid when reg_ready=1
- reg_ready  in  1  back-end completion; level, sampled from cycle after strobe
- cycle_err  out  1  one-cycle pulse when a cycle ends in SYNC error

## Operation
- States: IDLE, CTDIR, ADDR (4 nibbles, 2-bit counter), WDATA (2 nibbles), HTAR0, HTAR1, SYNC, RDATA (2 nibbles), TTAR0, TTAR1.
- IDLE→CTDIR: lpc_frame=0 and lpc_ad=4'h0 at a rising edge. Other START codes are ignored (stay IDLE).
- CTDIR: lpc_frame=1 required. lpc_ad[3:1]=3'b000 selects IORD; 3'b001 selects IOWR. Anything else → IDLE.
- ADDR: nibbles MSB first (A[15:12] … A[3:0]). After the 4th nibble, hit = (addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]). Miss → IDLE, never drives LAD, no strobes.
- WDATA (IOWR): low nibble first, then high nibble → reg_wdata.
- HTAR0/HTAR1: host turnaround; target does not drive. In HTAR0, register the offset on reg_addr and pulse reg_wr (IOWR) or reg_rd (IORD) for exactly one cycle.
- SYNC: target drives lpc_ad.
  - 4'h0 (ready) if reg_ready was sampled 1 in HTAR1 or any earlier SYNC cycle; reg_rdata is captured on that same sample.
  - Otherwise 4'h6 (long wait), incrementing an 8-bit wait counter.
  - After WAIT_MAX cycles of 4'h6, drive 4'hA (error) once and pulse cycle_err.
- After the final SYNC (0x0 or 0xA): IORD → RDATA; IOWR → TTAR0.
- RDATA: drive low nibble, then high nibble. Data is the captured reg_rdata, or 8'hFF after an error.
- TTAR0: drive 4'hF. TTAR1: Z. Then → IDLE.
- Abort: lpc_frame=0 in any non-IDLE state releases LAD (Z) immediately and returns to IDLE.
  - If lpc_ad=0 in that same cycle, the abort cycle counts as a new START → CTDIR.
  - A strobe already issued is not retracted; a late reg_ready is ignored.
- reg_ready asserted outside HTAR1/SYNC is ignored.

## Timing
- Reset (lpc_rst=0, asynchronous): state IDLE, lpc_ad Z, reg_wr=0, reg_rd=0, cycle_err=0, reg_addr=0, reg_wdata=0, wait counter 0.
- Deassertion is synchronised in: the first START is accepted no earlier than the 2nd rising edge after lpc_rst rises.
- Reset mid-cycle: LAD goes Z without waiting for a clock.
- IOWR with immediate ready = 12 clocks START→TTAR1: 1+1+4+2+2+1+1.
- IORD with immediate ready = 12 clocks: 1+1+4+2+1+2+1.
- Each cycle reg_ready is late adds exactly one 0x6 SYNC cycle.
- The strobe is high in HTAR0 only. reg_addr and reg_wdata are stable from HTAR0 until the next strobe.
- LAD is driven from SYNC through TTAR0 only; never driven in two consecutive cycles by host and target.

## Test plan
- IOWR 0x03F8 data 0x5A, reg_ready tied 1 → reg_wr one cycle, reg_addr=0, reg_wdata=0x5A; SYNC 0x0; TTAR 0xF then Z; 12 clocks total.
- IORD 0x03FD, reg_rdata=0x60, reg_ready rises 3 cycles after reg_rd → reg_addr=5; SYNC 6,6,0; LAD data 0x0 then 0x6; cycle_err stays 0.
- IORD 0x02F8 (miss) and CTDIR=4'h4 (memory cycle) → no strobe; LAD Z throughout; back in IDLE for the next START.
- WAIT_MAX=8, reg_ready held 0 → eight 0x6 SYNC cycles, then 0xA with cycle_err pulse; read data nibbles F,F.
- lpc_frame low after the 2nd address nibble with lpc_ad=0 → abort without strobe; a following IOWR 0x03F9 of 0xA5 completes normally with reg_addr=1.
- lpc_rst low during SYNC → LAD Z before the next edge, outputs at reset values; after release, a full IOWR succeeds.
